// File: rtl/fetch_if.sv
// Instruction-fetch bundle: instruction-memory request/response, redirect
// input and fetch-queue write port.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_full;
  logic        fq_write_en;
  logic [63:0] fq_write_data;

  modport master (
    output imem_req_valid, imem_req_addr, fq_write_en, fq_write_data,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, fq_full
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fq_write_en, fq_write_data,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, fq_full
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: one request per PC, response pushed
// into the fetch queue, with redirect squashing of in-flight fetches.
//
// state | meaning
// REQ   | request for PC presented, waiting for the memory handshake
// WAIT  | request accepted, waiting for its response
// HOLD  | response captured while queue full, waiting for space
// DROP  | request in flight is stale (redirected); swallow its response
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_instr;
  logic [31:0] redir_pc;
  logic        handshake;
  logic        write_fire;

  assign redir_pc  = {bus.redirect_pc[31:2], 2'b00};
  assign handshake = bus.imem_req_valid && bus.imem_req_ready;

  // A write needs a response (fresh or held), queue space and no redirect.
  assign write_fire = !reset && !bus.redirect_valid && !bus.fq_full &&
                      ((state == S_WAIT && bus.imem_rsp_valid) || state == S_HOLD);

  assign bus.imem_req_valid = !reset && (state == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.fq_write_en    = write_fire;
  assign bus.fq_write_data  = write_fire
                              ? {pc, (state == S_HOLD) ? hold_instr : bus.imem_rsp_data}
                              : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_instr <= 32'd0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            pc    <= redir_pc;
            state <= handshake ? S_DROP : S_REQ;
          end else if (handshake) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            pc    <= redir_pc;
            state <= bus.imem_rsp_valid ? S_REQ : S_DROP;
          end else if (bus.imem_rsp_valid) begin
            if (bus.fq_full) begin
              hold_instr <= bus.imem_rsp_data;
              state      <= S_HOLD;
            end else begin
              pc    <= pc + 32'd4;
              state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            pc    <= redir_pc;
            state <= S_REQ;
          end else if (!bus.fq_full) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.redirect_valid) pc <= redir_pc;
          if (bus.imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
